// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-4 demultiplexer: state encoding,
// channel indices and the default width of the optional transfer counters.
package demux_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam logic [1:0] CH0 = 2'd0;
    localparam logic [1:0] CH1 = 2'd1;
    localparam logic [1:0] CH2 = 2'd2;
    localparam logic [1:0] CH3 = 2'd3;

    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/demux_chan_cnt.sv
// Single wrapping transfer counter with enable; one instance per channel when
// DEMUX_1TO4_STATS_EN is defined.
module demux_chan_cnt
    import demux_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready flow control and a single
// holding stage. Define DEMUX_1TO4_STATS_EN to add per-channel transfer counters.
module demux_1to4_reg
    import demux_pkg::*;
#(
    parameter int size = 32
`ifdef DEMUX_1TO4_STATS_EN
    ,
    parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [size-1:0] data_i,
    input  logic [1:0]      select_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [size-1:0] data0_o,
    output logic [size-1:0] data1_o,
    output logic [size-1:0] data2_o,
    output logic [size-1:0] data3_o,
    output logic            valid0_o,
    output logic            valid1_o,
    output logic            valid2_o,
    output logic            valid3_o,
    input  logic            ready0_i,
    input  logic            ready1_i,
    input  logic            ready2_i,
    input  logic            ready3_i
`ifdef DEMUX_1TO4_STATS_EN
    ,
    output logic [CNT_W-1:0] count0_o,
    output logic [CNT_W-1:0] count1_o,
    output logic [CNT_W-1:0] count2_o,
    output logic [CNT_W-1:0] count3_o
`endif
);

    state_e          state_q;
    state_e          state_d;
    logic [size-1:0] data_q;
    logic [size-1:0] data_d;
    logic [1:0]      sel_q;
    logic [1:0]      sel_d;

    logic [3:0] readyVec;
    logic       selRdy;
    logic       accept;
    logic       drain;
    logic [3:0] validVec;

    // Only the consumer of the held word matters; other channels' ready is ignored.
    assign readyVec = {ready3_i, ready2_i, ready1_i, ready0_i};
    assign selRdy   = readyVec[sel_q];
    assign ready_o  = (state_q == ST_EMPTY) || selRdy;
    assign accept   = valid_i && ready_o;
    assign drain    = (state_q == ST_FULL) && selRdy;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                    data_d  = data_i;
                    sel_d   = select_i;
                end
            end
            ST_FULL: begin
                if (drain && accept) begin
                    data_d = data_i;
                    sel_d  = select_i;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= CH0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign validVec[0] = (state_q == ST_FULL) && (sel_q == CH0);
    assign validVec[1] = (state_q == ST_FULL) && (sel_q == CH1);
    assign validVec[2] = (state_q == ST_FULL) && (sel_q == CH2);
    assign validVec[3] = (state_q == ST_FULL) && (sel_q == CH3);

    assign valid0_o = validVec[0];
    assign valid1_o = validVec[1];
    assign valid2_o = validVec[2];
    assign valid3_o = validVec[3];

    // Idle channels present zero rather than a stale held word.
    assign data0_o = validVec[0] ? data_q : '0;
    assign data1_o = validVec[1] ? data_q : '0;
    assign data2_o = validVec[2] ? data_q : '0;
    assign data3_o = validVec[3] ? data_q : '0;

`ifdef DEMUX_1TO4_STATS_EN
    demux_chan_cnt #(.CNT_W(CNT_W)) u_cnt0 (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (drain && (sel_q == CH0)),
        .count_o(count0_o)
    );
    demux_chan_cnt #(.CNT_W(CNT_W)) u_cnt1 (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (drain && (sel_q == CH1)),
        .count_o(count1_o)
    );
    demux_chan_cnt #(.CNT_W(CNT_W)) u_cnt2 (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (drain && (sel_q == CH2)),
        .count_o(count2_o)
    );
    demux_chan_cnt #(.CNT_W(CNT_W)) u_cnt3 (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (drain && (sel_q == CH3)),
        .count_o(count3_o)
    );
`endif

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Self-checking bench for demux_1to4_reg: directed scenarios plus random traffic
// compared every cycle against a one-slot behavioural model.
module tb_demux_1to4_reg;

    localparam int SIZE = 32;
`ifdef DEMUX_1TO4_STATS_EN
    localparam int CNT_W = 16;
`endif

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [SIZE-1:0] data_i;
    logic [1:0]      select_i;
    logic            valid_i;
    logic            ready_o;
    logic [SIZE-1:0] data0_o, data1_o, data2_o, data3_o;
    logic            valid0_o, valid1_o, valid2_o, valid3_o;
    logic            ready0_i, ready1_i, ready2_i, ready3_i;
`ifdef DEMUX_1TO4_STATS_EN
    logic [CNT_W-1:0] count0_o, count1_o, count2_o, count3_o;
`endif

    int checks = 0;
    int errors = 0;

    // Model: at most one word in flight, remembered with its destination.
    logic            heldValid = 1'b0;
    logic [SIZE-1:0] heldData  = '0;
    logic [1:0]      heldSel   = 2'd0;
`ifdef DEMUX_1TO4_STATS_EN
    logic [CNT_W-1:0] expCount [4] = '{default: '0};
`endif

    always #5 clk_i = ~clk_i;

    demux_1to4_reg #(.size(SIZE)
`ifdef DEMUX_1TO4_STATS_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .select_i(select_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data0_o (data0_o),
        .data1_o (data1_o),
        .data2_o (data2_o),
        .data3_o (data3_o),
        .valid0_o(valid0_o),
        .valid1_o(valid1_o),
        .valid2_o(valid2_o),
        .valid3_o(valid3_o),
        .ready0_i(ready0_i),
        .ready1_i(ready1_i),
        .ready2_i(ready2_i),
        .ready3_i(ready3_i)
`ifdef DEMUX_1TO4_STATS_EN
        ,
        .count0_o(count0_o),
        .count1_o(count1_o),
        .count2_o(count2_o),
        .count3_o(count3_o)
`endif
    );

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Inputs change just after the rising edge and are sampled at the next one.
    task automatic applyStimulus(input logic v, input logic [1:0] sel,
                                 input logic [SIZE-1:0] d, input logic [3:0] rdy,
                                 input logic r);
        @(posedge clk_i);
        #1;
        valid_i  = v;
        select_i = sel;
        data_i   = d;
        {ready3_i, ready2_i, ready1_i, ready0_i} = rdy;
        rst_i    = r;
    endtask

    // Compare the DUT against the model mid-cycle, then advance the model
    // with the inputs that the coming rising edge will sample.
    always @(negedge clk_i) begin : monitor
        logic [3:0]   rdyIn;
        logic [3:0]   expValid;
        logic [127:0] expData;
        logic         expReady;
        logic         mDrain;
        rdyIn    = {ready3_i, ready2_i, ready1_i, ready0_i};
        expReady = !heldValid || rdyIn[heldSel];
        expValid = heldValid ? (4'b0001 << heldSel) : 4'b0000;
        for (int k = 0; k < 4; k++) begin
            expData[k*32 +: 32] = expValid[k] ? heldData : 32'd0;
        end
        checkOutput("valid3..0/ready",
                    {123'd0, valid3_o, valid2_o, valid1_o, valid0_o, ready_o},
                    {123'd0, expValid, expReady});
        checkOutput("data3..0", {data3_o, data2_o, data1_o, data0_o}, expData);
`ifdef DEMUX_1TO4_STATS_EN
        checkOutput("counts",
                    {64'd0, 16'(count3_o), 16'(count2_o), 16'(count1_o), 16'(count0_o)},
                    {64'd0, 16'(expCount[3]), 16'(expCount[2]), 16'(expCount[1]),
                     16'(expCount[0])});
`endif
        mDrain = heldValid && rdyIn[heldSel];
        if (rst_i) begin
            heldValid <= 1'b0;
            heldData  <= '0;
            heldSel   <= 2'd0;
`ifdef DEMUX_1TO4_STATS_EN
            for (int k = 0; k < 4; k++) expCount[k] <= '0;
`endif
        end else begin
`ifdef DEMUX_1TO4_STATS_EN
            if (mDrain) expCount[heldSel] <= expCount[heldSel] + 1'b1;
`endif
            if (valid_i && expReady) begin
                heldValid <= 1'b1;
                heldData  <= data_i;
                heldSel   <= select_i;
            end else if (mDrain) begin
                heldValid <= 1'b0;
            end
        end
    end

    initial begin
        rst_i    = 1'b1;
        valid_i  = 1'b1;
        select_i = 2'd1;
        data_i   = 32'h1234_5678;
        {ready3_i, ready2_i, ready1_i, ready0_i} = 4'b1111;

        // Reset held two cycles with traffic offered
        applyStimulus(1'b1, 2'd1, 32'h1234_5678, 4'b1111, 1'b1);
        applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111, 1'b0);
        @(negedge clk_i);
        checkOutput("reset ready_o", {127'd0, ready_o}, {127'd0, 1'b1});
        checkOutput("reset valids", {124'd0, valid3_o, valid2_o, valid1_o, valid0_o}, 128'd0);

        // Single transfer to channel 2
        applyStimulus(1'b1, 2'd2, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111, 1'b0);
        @(negedge clk_i);
        checkOutput("single data2", {96'd0, data2_o}, {96'd0, 32'hDEAD_BEEF});
        checkOutput("single valids", {124'd0, valid3_o, valid2_o, valid1_o, valid0_o},
                    {124'd0, 4'b0100});
        applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111, 1'b0);
        @(negedge clk_i);
        checkOutput("single empty", {124'd0, valid3_o, valid2_o, valid1_o, valid0_o}, 128'd0);

        // Back-to-back words to channels 0..3
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 2'(k), 32'h10 + 32'(k), 4'b1111, 1'b0);
        end
        @(negedge clk_i);
        checkOutput("b2b data2", {96'd0, data2_o}, {96'd0, 32'h12});
        checkOutput("b2b ready_o", {127'd0, ready_o}, {127'd0, 1'b1});
        applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111, 1'b0);
        @(negedge clk_i);
        checkOutput("b2b data3", {96'd0, data3_o}, {96'd0, 32'h13});

        // Backpressure: channel 1 stalls three cycles with 0x5A pending for ch0
        applyStimulus(1'b1, 2'd1, 32'hA5, 4'b1111, 1'b0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 2'd0, 32'h5A, 4'b0001, 1'b0);
            @(negedge clk_i);
            checkOutput("stall data1", {96'd0, data1_o}, {96'd0, 32'hA5});
            checkOutput("stall ready_o", {127'd0, ready_o}, 128'd0);
        end
        applyStimulus(1'b1, 2'd0, 32'h5A, 4'b1111, 1'b0);
        @(negedge clk_i);
        checkOutput("release ready_o", {127'd0, ready_o}, {127'd0, 1'b1});
        applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111, 1'b0);
        @(negedge clk_i);
        checkOutput("release data0", {96'd0, data0_o}, {96'd0, 32'h5A});
        checkOutput("release valids", {124'd0, valid3_o, valid2_o, valid1_o, valid0_o},
                    {124'd0, 4'b0001});

        // Reset while channel 3 holds an undelivered word
        applyStimulus(1'b1, 2'd3, 32'h77, 4'b0111, 1'b0);
        applyStimulus(1'b0, 2'd0, 32'h0, 4'b0111, 1'b1);
        @(negedge clk_i);
        checkOutput("midrst held", {96'd0, data3_o}, {96'd0, 32'h77});
        applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111, 1'b0);
        @(negedge clk_i);
        checkOutput("midrst valid3", {127'd0, valid3_o}, 128'd0);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
                          4'($urandom) | 4'($urandom), $urandom_range(0, 39) == 0);
        end
        applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111, 1'b0);
        applyStimulus(1'b0, 2'd0, 32'h0, 4'b1111, 1'b0);
        @(negedge clk_i);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
